// File: rtl/uart_psram_cmd_if.sv
// ---------------------------------------------------------------------------
// uart_psram_cmd_if
// Bundles the UART byte streams and the QPI PSRAM controller command signals
// seen by uart_psram_cmd.
//   master : the command stage (drives tx_*, ps_quad_start/read_write/
//            address/data_in and the status flags busy/overrun/timeout_err)
//   slave  : the environment (UART receiver/transmitter + PSRAM controller)
// Signals:
//   rx_data/rx_valid          received UART byte + one-cycle strobe
//   tx_data/tx_valid/tx_ready byte to the UART transmitter, valid/ready
//   ps_qpi_on                 controller initialised and in QPI mode
//   ps_endcommand             controller transaction complete
//   ps_data_out               controller read data
//   ps_quad_start             one-cycle transaction start pulse
//   ps_read_write             2 = read, 1 = write, 0 = none
//   ps_address/ps_data_in     word address / write data
//   busy/overrun/timeout_err  status flags
// ---------------------------------------------------------------------------
interface uart_psram_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ps_qpi_on;
  logic        ps_endcommand;
  logic [15:0] ps_data_out;
  logic        ps_quad_start;
  logic [1:0]  ps_read_write;
  logic [22:0] ps_address;
  logic [15:0] ps_data_in;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, ps_qpi_on, ps_endcommand, ps_data_out,
    output tx_data, tx_valid, ps_quad_start, ps_read_write, ps_address,
           ps_data_in, busy, overrun, timeout_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, ps_qpi_on, ps_endcommand, ps_data_out,
    input  tx_data, tx_valid, ps_quad_start, ps_read_write, ps_address,
           ps_data_in, busy, overrun, timeout_err
  );
endinterface

// File: rtl/uart_psram_cmd.sv
// ---------------------------------------------------------------------------
// uart_psram_cmd
// Parses a UART byte stream into single-word PSRAM transactions:
//   write frame: 'W' A2 A1 A0 D1 D0     read frame: 'R' A2 A1 A0
// Address = {A2[6:0],A1,A0}, data = {D1,D0}. A transaction is issued to the
// QPI controller once it reports QPI mode, and the result is returned on the
// UART transmit side: two data bytes (MSB first) for a read, RSP_ACK for a
// write, RSP_ERR for an unknown opcode, RSP_TMO when endcommand never came.
// Ports:
//   mem_clk : system clock shared with the PSRAM controller
//   rst_n   : asynchronous active-low reset
//   bus     : uart_psram_cmd_if.master (UART + PSRAM command + status)
// ---------------------------------------------------------------------------
module uart_psram_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52,
  parameter logic [7:0]  RSP_ACK        = 8'h4B,
  parameter logic [7:0]  RSP_ERR        = 8'h3F,
  parameter logic [7:0]  RSP_TMO        = 8'hEE
) (
  input  logic             mem_clk,
  input  logic             rst_n,
  uart_psram_cmd_if.master bus
);

  // Timeout counter is never narrower than 8 bits.
  localparam int unsigned CNT_W_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_MIN < 8) ? 8 : CNT_W_MIN;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, ADDR, DATA, WAIT_QPI, ISSUE, WAIT_END, TX_HI, TX_LO, TX_ONE
  } state_t;

  state_t           state;
  logic             is_read;
  logic [1:0]       idx;        // byte index inside the ADDR / DATA fields
  logic [6:0]       a2;         // A2[7] is dropped on capture
  logic [7:0]       a1;
  logic [7:0]       d1;
  logic [15:0]      resp;       // read data or status byte (in [7:0])
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      is_read           <= 1'b0;
      idx               <= 2'd0;
      a2                <= '0;
      a1                <= '0;
      d1                <= '0;
      resp              <= '0;
      tmo_cnt           <= '0;
      bus.tx_data       <= '0;
      bus.tx_valid      <= 1'b0;
      bus.ps_quad_start <= 1'b0;
      bus.ps_read_write <= 2'd0;
      bus.ps_address    <= '0;
      bus.ps_data_in    <= '0;
      bus.busy          <= 1'b0;
      bus.overrun       <= 1'b0;
      bus.timeout_err   <= 1'b0;
    end else begin
      bus.ps_quad_start <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            bus.busy <= 1'b1;
            idx      <= 2'd0;
            if (bus.rx_data == OP_WRITE) begin
              is_read <= 1'b0;
              state   <= ADDR;
            end else if (bus.rx_data == OP_READ) begin
              is_read <= 1'b1;
              state   <= ADDR;
            end else begin
              resp  <= {8'h00, RSP_ERR};
              state <= TX_ONE;
            end
          end
        end

        ADDR: begin
          if (bus.rx_valid) begin
            case (idx)
              2'd0: begin
                a2  <= bus.rx_data[6:0];
                idx <= 2'd1;
              end
              2'd1: begin
                a1  <= bus.rx_data;
                idx <= 2'd2;
              end
              default: begin
                bus.ps_address <= {a2, a1, bus.rx_data};
                idx            <= 2'd0;
                if (is_read) begin
                  bus.ps_read_write <= 2'd2;
                  state             <= WAIT_QPI;
                end else begin
                  state <= DATA;
                end
              end
            endcase
          end
        end

        DATA: begin
          if (bus.rx_valid) begin
            if (idx == 2'd0) begin
              d1  <= bus.rx_data;
              idx <= 2'd1;
            end else begin
              bus.ps_data_in    <= {d1, bus.rx_data};
              bus.ps_read_write <= 2'd1;
              state             <= WAIT_QPI;
            end
          end
        end

        // Command fields are already registered and stay put until the
        // transaction ends, so the controller only needs the start pulse.
        WAIT_QPI: begin
          if (bus.ps_qpi_on) begin
            bus.ps_quad_start <= 1'b1;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT_END;
        end

        // endcommand is tested first so it wins over a simultaneous timeout.
        WAIT_END: begin
          if (bus.ps_endcommand) begin
            bus.ps_read_write <= 2'd0;
            if (is_read) begin
              resp  <= bus.ps_data_out;
              state <= TX_HI;
            end else begin
              resp  <= {8'h00, RSP_ACK};
              state <= TX_ONE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            bus.ps_read_write <= 2'd0;
            bus.timeout_err   <= 1'b1;
            resp              <= {8'h00, RSP_TMO};
            state             <= TX_ONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        // Each TX state raises tx_valid one cycle after entry and drops it
        // the cycle after the handshake, which leaves an idle cycle between
        // the two bytes of a read response.
        TX_HI: begin
          if (!bus.tx_valid) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= resp[15:8];
          end else if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            state        <= TX_LO;
          end
        end

        TX_LO, TX_ONE: begin
          if (!bus.tx_valid) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= resp[7:0];
          end else if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase

      // No backpressure on rx: bytes arriving outside frame parsing are lost.
      if (bus.rx_valid &&
          (state inside {WAIT_QPI, ISSUE, WAIT_END, TX_HI, TX_LO, TX_ONE})) begin
        bus.overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_psram_cmd.sv
// ---------------------------------------------------------------------------
// tb_uart_psram_cmd
// Randomised frames against a reference model: a word memory keyed by the
// frame address predicts read data and response bytes, while a separate
// PSRAM responder model answers the DUT's quad_start requests.
// ---------------------------------------------------------------------------
module tb_uart_psram_cmd;
  localparam int TMO = 255;

  logic mem_clk = 1'b0;
  logic rst_n;

  uart_psram_cmd_if bus();

  uart_psram_cmd #(.TIMEOUT_CYCLES(TMO)) dut (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial forever #5 mem_clk = ~mem_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge mem_clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Environment / model state
  logic [15:0] psram_mem [int];
  logic [15:0] ref_mem   [int];
  bit          pending   = 1'b0;
  bit          withhold  = 1'b0;
  int          cd        = 0;
  int          end_delay = 0;
  int          pulse_cnt = 0;
  int          qs_cyc    = 0;
  int          end_cyc   = 0;
  int          last_cyc  = 0;
  logic [1:0]  q_rw;
  logic [22:0] q_addr;
  logic [15:0] q_data;
  logic [7:0]  tx_q [$];
  int          rise_q [$];
  bit          rdy_rand  = 1'b0;
  logic        rdy_fixed = 1'b1;
  bit          exp_ovr   = 1'b0;
  bit          exp_tmo   = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  // Content of a never-written PSRAM word.
  function automatic logic [15:0] fill_word(input logic [22:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge mem_clk);
    if (rst_n !== 1'b1) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (bus.ps_quad_start) begin
        pulse_cnt++;
        qs_cyc = cyc;
        chk("qpi_on_at_start", 32'(bus.ps_qpi_on), 32'd1);
        chk("one_in_flight", 32'(pending), 32'd0);
        q_rw    = bus.ps_read_write;
        q_addr  = bus.ps_address;
        q_data  = bus.ps_data_in;
        pending = 1'b1;
        cd      = end_delay;
      end
      if (prev_hs) chk("tx_gap", 32'(bus.tx_valid), 32'd0);
      if (bus.tx_valid && prev_valid && !prev_ready)
        chk("tx_hold", 32'(bus.tx_data), 32'(prev_data));
      if (bus.tx_valid && !prev_valid) rise_q.push_back(cyc);
      prev_hs = bus.tx_valid && bus.tx_ready;
      if (prev_hs) tx_q.push_back(bus.tx_data);
      prev_valid = bus.tx_valid;
      prev_ready = bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  // PSRAM controller model.
  initial forever begin
    step();
    bus.ps_endcommand = 1'b0;
    if (pending && !withhold && rst_n === 1'b1) begin
      if (cd > 0) begin
        cd--;
      end else begin
        chk("rw_stable", 32'(bus.ps_read_write), 32'(q_rw));
        chk("addr_stable", 32'(bus.ps_address), 32'(q_addr));
        if (q_rw == 2'd2) begin
          bus.ps_data_out = psram_mem.exists(int'(q_addr)) ? psram_mem[int'(q_addr)]
                                                          : fill_word(q_addr);
        end else begin
          bus.ps_data_out = 16'($urandom());
          psram_mem[int'(q_addr)] = bus.ps_data_in;
        end
        bus.ps_endcommand = 1'b1;
        end_cyc = cyc;
        pending = 1'b0;
      end
    end
  end

  // UART transmitter ready model.
  initial forever begin
    step();
    bus.tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_data"},     32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_valid"},    32'(bus.tx_valid), 32'd0);
    chk({tag, "_quad_start"},  32'(bus.ps_quad_start), 32'd0);
    chk({tag, "_read_write"},  32'(bus.ps_read_write), 32'd0);
    chk({tag, "_address"},     32'(bus.ps_address), 32'd0);
    chk({tag, "_data_in"},     32'(bus.ps_data_in), 32'd0);
    chk({tag, "_busy"},        32'(bus.busy), 32'd0);
    chk({tag, "_overrun"},     32'(bus.overrun), 32'd0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  // Called aligned to posedge+1; leaves rx_valid low at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    last_cyc     = cyc;
    step();
    bus.rx_valid = 1'b0;
  endtask

  // kind: 0 write, 1 read, 2 bad opcode, 3 read with endcommand withheld
  task automatic do_frame(input int kind, input logic [22:0] addr, input logic a2_top,
                          input logic [15:0] data, input logic [7:0] op_byte,
                          input int qpi_delay, input bit inject, input bit stall,
                          input int gap_max);
    logic [7:0]  fb [$];
    logic [7:0]  exp_tx [$];
    logic [15:0] rd;
    int          p0;
    int          t;
    int          d;
    step();
    p0 = pulse_cnt;
    tx_q.delete();
    rise_q.delete();
    withhold = (kind == 3);
    if (qpi_delay > 0) bus.ps_qpi_on = 1'b0;
    if (stall) rdy_fixed = 1'b0;

    case (kind)
      0:       fb.push_back(8'h57);
      1, 3:    fb.push_back(8'h52);
      default: fb.push_back(op_byte);
    endcase
    if (kind != 2) begin
      fb.push_back({a2_top, addr[22:16]});
      fb.push_back(addr[15:8]);
      fb.push_back(addr[7:0]);
    end
    if (kind == 0) begin
      fb.push_back(data[15:8]);
      fb.push_back(data[7:0]);
    end

    rd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : fill_word(addr);
    case (kind)
      0:       exp_tx.push_back(8'h4B);
      1: begin
        exp_tx.push_back(rd[15:8]);
        exp_tx.push_back(rd[7:0]);
      end
      2:       exp_tx.push_back(8'h3F);
      default: begin
        exp_tx.push_back(8'hEE);
        exp_tmo = 1'b1;
      end
    endcase

    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i]);
      if (i == 0) chk("busy_in_frame", 32'(bus.busy), 32'd1);
      if (i != fb.size() - 1) repeat ($urandom_range(0, gap_max)) step();
    end

    if (qpi_delay > 0) begin
      repeat (qpi_delay) step();
      if (inject) begin
        send_byte(8'hA5);
        exp_ovr = 1'b1;
        step();
        chk("overrun_set", 32'(bus.overrun), 32'd1);
      end
      chk("no_pulse_while_qpi_off", 32'(pulse_cnt - p0), 32'd0);
      bus.ps_qpi_on = 1'b1;
    end

    if (stall) begin
      t = 0;
      while (bus.tx_valid !== 1'b1 && t < 2000) begin
        @(negedge mem_clk);
        t++;
      end
      for (int i = 0; i < 10; i++) begin
        @(negedge mem_clk);
        chk("stall_valid", 32'(bus.tx_valid), 32'd1);
        chk("stall_data", 32'(bus.tx_data), 32'(exp_tx[0]));
      end
      rdy_fixed = 1'b1;
    end

    t = 0;
    while (tx_q.size() < exp_tx.size() && t < 2000) begin
      @(negedge mem_clk);
      t++;
    end
    repeat (4) @(negedge mem_clk);
    if (kind == 3) begin
      pending  = 1'b0;
      withhold = 1'b0;
    end

    chk("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < tx_q.size()) chk("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
    chk("pulse_count", 32'(pulse_cnt - p0), (kind == 2) ? 32'd0 : 32'd1);
    if (pulse_cnt != p0) begin
      chk("txn_rw", 32'(q_rw), (kind == 0) ? 32'd1 : 32'd2);
      chk("txn_addr", 32'(q_addr), 32'(addr));
      if (kind == 0) chk("txn_data", 32'(q_data), 32'(data));
      if (qpi_delay == 0) chk("start_latency", 32'(qs_cyc - last_cyc), 32'd2);
    end
    if (kind == 0 || kind == 1) begin
      d = (rise_q.size() > 0) ? rise_q[0] - end_cyc : -1;
      chk("end_to_valid", 32'(d), 32'd2);
    end
    if (kind == 3) begin
      d = (rise_q.size() > 0) ? rise_q[0] - qs_cyc : -1;
      chk("timeout_window", 32'((d >= TMO + 1) && (d <= TMO + 4)), 32'd1);
    end
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("rw_after", 32'(bus.ps_read_write), 32'd0);
    chk("timeout_err", 32'(bus.timeout_err), 32'(exp_tmo));
    chk("overrun", 32'(bus.overrun), 32'(exp_ovr));

    if (kind == 0) ref_mem[int'(addr)] = data;
    $display("[cyc %0d] frame kind=%0d addr=0x%06h data=0x%04h tx_bytes=%0d",
             cyc, kind, addr, data, tx_q.size());
  endtask

  initial begin
    logic [22:0] addr;
    logic [15:0] data;
    logic [7:0]  op;
    logic [22:0] wr_addrs [$];
    int          kind;
    int          p0;
    int          t;

    bus.rx_data       = 8'h00;
    bus.rx_valid      = 1'b0;
    bus.tx_ready      = 1'b1;
    bus.ps_qpi_on     = 1'b1;
    bus.ps_endcommand = 1'b0;
    bus.ps_data_out   = 16'h0000;
    rst_n             = 1'b0;

    repeat (3) @(negedge mem_clk);
    chk_zero("reset");
    step();
    rst_n = 1'b1;

    // Directed cases
    do_frame(0, 23'h012345, 1'b0, 16'hBEEF, 8'h00, 0, 1'b0, 1'b0, 0);
    chk("directed_wr_addr", 32'(q_addr), 32'h012345);
    psram_mem[int'(23'h010010)] = 16'h1234;
    ref_mem[int'(23'h010010)]   = 16'h1234;
    do_frame(1, 23'h010010, 1'b1, 16'h0000, 8'h00, 0, 1'b0, 1'b0, 1);
    chk("directed_rd_hi", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF, 32'h12);
    chk("directed_rd_lo", (tx_q.size() > 1) ? 32'(tx_q[1]) : 32'hFFFF, 32'h34);
    do_frame(2, 23'h0, 1'b0, 16'h0, 8'h41, 0, 1'b0, 1'b0, 0);
    do_frame(3, 23'h0, 1'b0, 16'h0, 8'h00, 0, 1'b0, 1'b0, 0);
    do_frame(0, 23'h000777, 1'b0, 16'h5AA5, 8'h00, 0, 1'b0, 1'b0, 2);
    do_frame(0, 23'(23'h2ABCDE), 1'b0, 16'hC0DE, 8'h00, 15, 1'b1, 1'b0, 0);
    do_frame(1, 23'h010010, 1'b0, 16'h0000, 8'h00, 0, 1'b0, 1'b1, 0);
    do_frame(0, 23'h7FFFFF, 1'b1, 16'hF00D, 8'h00, 0, 1'b0, 1'b0, 0);
    do_frame(1, 23'h7FFFFF, 1'b1, 16'h0000, 8'h00, 0, 1'b0, 1'b0, 0);
    wr_addrs.push_back(23'h7FFFFF);
    wr_addrs.push_back(23'h012345);

    // Randomised frames
    rdy_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 4);
      if (kind > 2) kind = $urandom_range(0, 1);
      addr = 23'($urandom());
      if (kind == 1 && wr_addrs.size() > 0 && $urandom_range(0, 1) == 1)
        addr = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
      data = 16'($urandom());
      op   = 8'($urandom());
      while (op == 8'h57 || op == 8'h52) op = 8'($urandom());
      end_delay = $urandom_range(0, 8);
      if (kind == 0) wr_addrs.push_back(addr);
      do_frame(kind, addr, 1'($urandom_range(0, 1)), data, op,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
               1'b0, 1'b0, 2);
    end
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    end_delay = 0;

    // Asynchronous reset while waiting for endcommand
    step();
    tx_q.delete();
    rise_q.delete();
    p0 = pulse_cnt;
    withhold = 1'b1;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    t = 0;
    while (!pending && t < 50) begin
      @(negedge mem_clk);
      t++;
    end
    step();
    chk("busy_before_reset", 32'(bus.busy), 32'd1);
    chk("rw_before_reset", 32'(bus.ps_read_write), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    pending  = 1'b0;
    withhold = 1'b0;
    exp_ovr  = 1'b0;
    exp_tmo  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();
    chk("no_tx_after_reset", 32'(tx_q.size() + rise_q.size()), 32'd0);
    chk("pulses_around_reset", 32'(pulse_cnt - p0), 32'd1);
    chk("busy_after_reset", 32'(bus.busy), 32'd0);
    $display("[cyc %0d] reset during WAIT_END, tx bytes after release=%0d", cyc, tx_q.size());

    do_frame(0, 23'h000123, 1'b0, 16'h4321, 8'h00, 0, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
